serial_parity_checker: RTL
==========================

SERIAL_PARITY_CHECKER -- requirements
Module: serial_parity_checker

Interface
REQ-001 SHALL have parameter DATA_W, default 8: data bits per frame, range 2..32.
REQ-002 SHALL have parameter PARITY_ODD, default 0: 0 selects even parity, 1 selects odd parity.
REQ-003 SHALL have port CLK, input, 1: the single clock; all state updates occur on its rising edge.
REQ-004 SHALL have port RST, input, 1: reset, asynchronous and active-high.
REQ-005 SHALL have port START, input, 1: frame start request, sampled only in IDLE.
REQ-006 SHALL have port BIT_IN, input, 1: serial data or parity bit.
REQ-007 SHALL have port BIT_VALID, input, 1: BIT_IN is qualified this cycle.
REQ-008 SHALL have port ABORT, input, 1: synchronous frame abandon.
REQ-009 SHALL have port BUSY, output, 1: high in DATA and PARITY states.
REQ-010 SHALL have port DATA_OUT, output, DATA_W: last completed frame's data, LSB received first.
REQ-011 SHALL have port PAR_CALC, output, 1: parity computed over the last completed frame.
REQ-012 SHALL have port FRAME_DONE, output, 1: one-cycle completion pulse.
REQ-013 SHALL have port PAR_ERR, output, 1: received parity bit differs from PAR_CALC; valid while FRAME_DONE is high and held until the next frame completes.

Function
REQ-014 SHALL implement FSM states IDLE, DATA, PARITY and DONE.
REQ-015 SHALL behave in IDLE as follows:
- START=1 clears the bit counter and sets the running parity to PARITY_ODD, then goes to DATA.
- BIT_VALID is ignored.
- START with BIT_VALID in the same cycle accepts START only.
REQ-016 SHALL, in DATA, on each BIT_VALID=1 cycle:
- shift BIT_IN into the shift register at position count (LSB first);
- update running parity to running XOR BIT_IN;
- increment the counter.
REQ-017 SHALL go from DATA to PARITY after the DATA_W-th valid bit; cycles with BIT_VALID=0 hold all state, so arbitrary gaps are allowed.
REQ-018 SHALL, in PARITY, on BIT_VALID=1, capture BIT_IN as the received parity and go to DONE.
REQ-019 SHALL, in DONE, for exactly one cycle:
- assert FRAME_DONE;
- drive DATA_OUT and PAR_CALC with the new frame's values;
- drive PAR_ERR = received parity XOR running parity;
- then return to IDLE.
REQ-020 SHALL give a latency of 1 cycle from the edge sampling the parity bit to FRAME_DONE=1.
REQ-021 SHALL ignore START in DATA, PARITY and DONE; a frame is never restarted.
REQ-022 SHALL, on ABORT=1 in DATA or PARITY, go to IDLE next cycle with no FRAME_DONE and leave DATA_OUT, PAR_CALC and PAR_ERR unchanged; ABORT has no effect in IDLE or DONE.
REQ-023 SHALL give ABORT priority over BIT_VALID in the same cycle.
REQ-024 SHALL size the counter to clog2(DATA_W+1) bits and SHALL never wrap within a frame.
REQ-025 SHALL keep DATA_OUT, PAR_CALC and PAR_ERR registered and stable between FRAME_DONE pulses.

Reset
REQ-026 SHALL, on RST=1, immediately set the FSM to IDLE, regardless of CLK.
REQ-027 SHALL, on RST=1, clear the counter and shift register.
REQ-028 SHALL, on RST=1, set BUSY=0, FRAME_DONE=0, PAR_ERR=0, PAR_CALC=0 and DATA_OUT=0.
REQ-029 SHALL discard any partial frame when reset is asserted mid-frame and SHALL emit no FRAME_DONE for it.
REQ-030 SHALL, after RST deasserts, accept START on the first rising CLK edge.

Structure
REQ-031 SHALL take the FSM state encoding (2-bit localparams) and the DATA_W default from shared package parity_pkg.
REQ-032 SHALL implement the running-parity update with one instance of the team's existing 2-input XOR_GATE cell, with the running-parity flop and BIT_IN as inputs.
REQ-033 SHALL contain no other sub-modules; FSM, counter and shift register are local.

Verification
REQ-034 SHALL cover this scenario with DATA_W=8 and PARITY_ODD=0: START, bits of 8'hA5, parity bit 0 -> FRAME_DONE=1 one cycle after the parity bit, DATA_OUT=8'hA5, PAR_CALC=0, PAR_ERR=0.
REQ-035 SHALL cover this scenario: same frame with parity bit 1 -> PAR_ERR=1, PAR_ERR held through the following IDLE cycles.
REQ-036 SHALL cover this scenario with PARITY_ODD=1: data 8'h01, parity bit 0 -> PAR_CALC=0, PAR_ERR=0.
REQ-037 SHALL cover this scenario: 8'h3C sent with 2-cycle BIT_VALID gaps plus a START pulse mid-frame -> frame unaffected, DATA_OUT=8'h3C, single FRAME_DONE.
REQ-038 SHALL cover this scenario: RST asserted after 3 data bits -> outputs zero immediately, no FRAME_DONE; a following full frame 8'hFF with parity 0 -> PAR_ERR=0.
REQ-039 SHALL cover this scenario: ABORT with BIT_VALID in the same cycle after 5 bits -> IDLE, no FRAME_DONE, previous DATA_OUT retained.

Source files
------------

// File: rtl/parity_pkg.sv
// Shared constants for the serial parity checker: FSM state encoding and default frame width.
package parity_pkg;

    localparam int DATA_W_DEF = 8;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DATA   = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

endpackage

// File: rtl/XOR_GATE.sv
// Two-input XOR cell from the shared cell library.
module XOR_GATE (
    input  logic a_i,
    input  logic b_i,
    output logic y_o
);

    assign y_o = a_i ^ b_i;

endmodule

// File: rtl/serial_parity_checker.sv
// Receives DATA_W serial bits (LSB first) followed by one parity bit and reports
// the assembled word, the computed parity and a parity-mismatch flag.
module serial_parity_checker
    import parity_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int PARITY_ODD = 0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    input  logic              BIT_IN,
    input  logic              BIT_VALID,
    input  logic              ABORT,
    output logic              BUSY,
    output logic [DATA_W-1:0] DATA_OUT,
    output logic              PAR_CALC,
    output logic              FRAME_DONE,
    output logic              PAR_ERR,
    output logic [1:0]        DBG_STATE
);

    localparam int               CNT_W    = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
    localparam logic             PAR_INIT = (PARITY_ODD != 0);

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              run_par_q, run_par_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              par_calc_q, par_calc_d;
    logic              par_err_q, par_err_d;
    logic              par_xor;

    // Same XOR serves the running-parity update in DATA and the mismatch in PARITY.
    XOR_GATE u_par_xor (
        .a_i (run_par_q),
        .b_i (BIT_IN),
        .y_o (par_xor)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (START) state_d = ST_DATA;
            end
            ST_DATA: begin
                if (ABORT) begin
                    state_d = ST_IDLE;
                end else if (BIT_VALID && (cnt_q == LAST_BIT)) begin
                    state_d = ST_PARITY;
                end
            end
            ST_PARITY: begin
                if (ABORT) begin
                    state_d = ST_IDLE;
                end else if (BIT_VALID) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        BUSY       = (state_q == ST_DATA) || (state_q == ST_PARITY);
        FRAME_DONE = (state_q == ST_DONE);
        DBG_STATE  = state_q;
        DATA_OUT   = data_out_q;
        PAR_CALC   = par_calc_q;
        PAR_ERR    = par_err_q;
    end

    always_comb begin
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        run_par_d  = run_par_q;
        data_out_d = data_out_q;
        par_calc_d = par_calc_q;
        par_err_d  = par_err_q;
        if ((state_q == ST_IDLE) && START) begin
            cnt_d     = '0;
            run_par_d = PAR_INIT;
        end else if ((state_q == ST_DATA) && !ABORT && BIT_VALID) begin
            for (int i = 0; i < DATA_W; i++) begin
                if (cnt_q == CNT_W'(i)) shift_d[i] = BIT_IN;
            end
            run_par_d = par_xor;
            cnt_d     = cnt_q + CNT_W'(1);
        end else if ((state_q == ST_PARITY) && !ABORT && BIT_VALID) begin
            // Results are latched on the parity edge so they are visible during DONE.
            data_out_d = shift_q;
            par_calc_d = run_par_q;
            par_err_d  = par_xor;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_q      <= '0;
            shift_q    <= '0;
            run_par_q  <= 1'b0;
            data_out_q <= '0;
            par_calc_q <= 1'b0;
            par_err_q  <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            run_par_q  <= run_par_d;
            data_out_q <= data_out_d;
            par_calc_q <= par_calc_d;
            par_err_q  <= par_err_d;
        end
    end

endmodule
